// File: rtl/lsq_fwd_queue_if.sv
// rtl/lsq_fwd_queue_if.sv - core-side and memory-side signal bundle for the load/store queue
interface lsq_fwd_queue_if #(
  parameter int IDW = 4,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int CW  = 16,
  parameter int ZW  = 4
);
  // core request side
  logic          memR;
  logic          memW;
  logic [AW-1:0] addr_in_C;
  logic [DW-1:0] data_in_C;
  logic [CW-1:0] cntrl_in_C;
  logic [ZW-1:0] Z_in_C;
  logic          full_out_C;
  logic          empty;
  // core retirement side
  logic [AW-1:0] addr_out_C;
  logic [DW-1:0] data_out_C;
  logic [CW-1:0] cntrl_out_C;
  logic [ZW-1:0] Z_out_C;
  logic          ready_out_C;
  // memory request side
  logic [AW-1:0]  addr_out_M;
  logic [DW-1:0]  data_out_M;
  logic           rw_out_M;
  logic [IDW-1:0] ldstID_out_M;
  logic           valid_out_M;
  logic           stall_in_M;
  // memory completion side
  logic [DW-1:0]  data_in_M;
  logic [IDW-1:0] ldstID_in_M;
  logic           ready_in_M;

  modport master (
    output memR, memW, addr_in_C, data_in_C, cntrl_in_C, Z_in_C,
    output stall_in_M, data_in_M, ldstID_in_M, ready_in_M,
    input  full_out_C, empty,
    input  addr_out_C, data_out_C, cntrl_out_C, Z_out_C, ready_out_C,
    input  addr_out_M, data_out_M, rw_out_M, ldstID_out_M, valid_out_M
  );

  modport slave (
    input  memR, memW, addr_in_C, data_in_C, cntrl_in_C, Z_in_C,
    input  stall_in_M, data_in_M, ldstID_in_M, ready_in_M,
    output full_out_C, empty,
    output addr_out_C, data_out_C, cntrl_out_C, Z_out_C, ready_out_C,
    output addr_out_M, data_out_M, rw_out_M, ldstID_out_M, valid_out_M
  );
endinterface

// File: rtl/lsq_fwd_queue.sv
// rtl/lsq_fwd_queue.sv - in-order load/store queue with store-to-load forwarding
module lsq_fwd_queue #(
  parameter int DEPTH = 16,
  parameter int IDW   = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CW    = 16,
  parameter int ZW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  lsq_fwd_queue_if.slave    lsq
);

  localparam logic [IDW:0] L_FULL = (IDW+1)'(DEPTH);

  // queue pointers and occupancy
  logic [IDW-1:0] r_head;
  logic [IDW-1:0] r_tail;
  logic [IDW-1:0] r_issue;
  logic [IDW:0]   r_count;

  // per-entry status
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_issued;
  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_store;

  // per-entry payload
  logic [AW-1:0] r_addr  [DEPTH];
  logic [DW-1:0] r_data  [DEPTH];
  logic [CW-1:0] r_cntrl [DEPTH];
  logic [ZW-1:0] r_z     [DEPTH];

  // registered outputs
  logic [AW-1:0]  r_addr_out_C;
  logic [DW-1:0]  r_data_out_C;
  logic [CW-1:0]  r_cntrl_out_C;
  logic [ZW-1:0]  r_z_out_C;
  logic           r_ready_out_C;
  logic [AW-1:0]  r_addr_out_M;
  logic [DW-1:0]  r_data_out_M;
  logic           r_rw_out_M;
  logic [IDW-1:0] r_id_out_M;
  logic           r_valid_out_M;

  logic           w_full;
  logic           w_empty;
  logic           w_enq;
  logic           w_fwd_hit;
  logic [DW-1:0]  w_fwd_data;
  logic [IDW-1:0] w_fidx;
  logic           w_fwd;
  logic           w_iss_pend;
  logic           w_iss_skip;
  logic           w_iss_go;
  logic           w_cmp;
  logic           w_ret;
  logic [IDW-1:0] w_cid;

  assign w_full  = (r_count == L_FULL);
  assign w_empty = (r_count == '0);
  assign w_enq   = (lsq.memR | lsq.memW) & ~w_full;
  assign w_fwd   = w_fwd_hit & ~lsq.memW;

  // Issue is pending while the issue pointer trails the tail; when the queue is full the
  // pointers coincide, so the entry's own issued bit tells "nothing issued" from "all issued".
  assign w_iss_pend = (r_issue != r_tail) | (w_full & ~r_issued[r_issue]);
  assign w_iss_skip = w_iss_pend & r_issued[r_issue];
  assign w_iss_go   = w_iss_pend & ~r_issued[r_issue] & ~lsq.stall_in_M;

  assign w_cid = lsq.ldstID_in_M;
  assign w_cmp = lsq.ready_in_M & r_valid[w_cid] & r_issued[w_cid] & ~r_done[w_cid];
  assign w_ret = r_valid[r_head] & r_done[r_head];

  // Walk older entries oldest-to-youngest so the youngest matching store wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_fidx     = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_fidx = r_head + IDW'(k);
      if (((IDW+1)'(k) < r_count) && r_valid[w_fidx] && r_store[w_fidx] &&
          (r_addr[w_fidx][AW-1:2] == lsq.addr_in_C[AW-1:2])) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[w_fidx];
      end
    end
  end

  // Pointer, count and entry status bookkeeping for enqueue, issue, completion and retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_issue  <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      r_issued <= '0;
      r_done   <= '0;
      r_store  <= '0;
    end else begin
      if (w_iss_go) begin
        r_issued[r_issue] <= 1'b1;
      end
      if (w_iss_go | w_iss_skip) begin
        r_issue <= r_issue + 1'b1;
      end
      if (w_cmp) begin
        r_done[w_cid] <= 1'b1;
      end
      if (w_ret) begin
        r_valid[r_head]  <= 1'b0;
        r_issued[r_head] <= 1'b0;
        r_done[r_head]   <= 1'b0;
        r_head           <= r_head + 1'b1;
      end
      if (w_enq) begin
        r_valid[r_tail]  <= 1'b1;
        r_issued[r_tail] <= w_fwd;
        r_done[r_tail]   <= w_fwd;
        r_store[r_tail]  <= lsq.memW;
        r_tail           <= r_tail + 1'b1;
      end
      case ({w_enq, w_ret})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload capture; load results land here on completion, forwarded data at enqueue.
  always_ff @(posedge clk) begin
    if (w_cmp && !r_store[w_cid]) begin
      r_data[w_cid] <= lsq.data_in_M;
    end
    if (w_enq) begin
      r_addr[r_tail]  <= lsq.addr_in_C;
      r_data[r_tail]  <= w_fwd ? w_fwd_data : lsq.data_in_C;
      r_cntrl[r_tail] <= lsq.cntrl_in_C;
      r_z[r_tail]     <= lsq.Z_in_C;
    end
  end

  // Memory request and core retirement output registers; payloads hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_out_M <= 1'b0;
      r_addr_out_M  <= '0;
      r_data_out_M  <= '0;
      r_rw_out_M    <= 1'b0;
      r_id_out_M    <= '0;
      r_ready_out_C <= 1'b0;
      r_addr_out_C  <= '0;
      r_data_out_C  <= '0;
      r_cntrl_out_C <= '0;
      r_z_out_C     <= '0;
    end else begin
      r_valid_out_M <= w_iss_go;
      if (w_iss_go) begin
        r_addr_out_M <= r_addr[r_issue];
        r_data_out_M <= r_data[r_issue];
        r_rw_out_M   <= r_store[r_issue];
        r_id_out_M   <= r_issue;
      end
      r_ready_out_C <= w_ret;
      if (w_ret) begin
        r_addr_out_C  <= r_addr[r_head];
        r_data_out_C  <= r_data[r_head];
        r_cntrl_out_C <= r_cntrl[r_head];
        r_z_out_C     <= r_z[r_head];
      end
    end
  end

  assign lsq.full_out_C   = w_full;
  assign lsq.empty        = w_empty;
  assign lsq.addr_out_C   = r_addr_out_C;
  assign lsq.data_out_C   = r_data_out_C;
  assign lsq.cntrl_out_C  = r_cntrl_out_C;
  assign lsq.Z_out_C      = r_z_out_C;
  assign lsq.ready_out_C  = r_ready_out_C;
  assign lsq.addr_out_M   = r_addr_out_M;
  assign lsq.data_out_M   = r_data_out_M;
  assign lsq.rw_out_M     = r_rw_out_M;
  assign lsq.ldstID_out_M = r_id_out_M;
  assign lsq.valid_out_M  = r_valid_out_M;

endmodule
